pico_frame_decoder: RTL and testbench
=====================================

PICO_FRAME_DECODER -- requirements
Module: pico_frame_decoder

Interface
REQ-001 Parameter DATA_W, default 8, serial word width in bits (legal values 4..32).
REQ-002 Parameter NUM_REGS, default 16, number of addressable target registers (legal values 2..256, NUM_REGS <= 2^DATA_W).
REQ-003 Derived localparam ADDR_W = $clog2(NUM_REGS).
REQ-004 sclk  input  1  SPI clock; all sequential logic on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 csn  input  1  chip select, active-low; high = no frame.
REQ-007 serial_in  input  1  serial data, MSB first, sampled on sclk rising edge.
REQ-008 wr_en  output  1  write strobe to register bank.
REQ-009 wr_addr  output  ADDR_W  target register of current write.
REQ-010 wr_data  output  DATA_W  data of current write.
REQ-011 rd_addr  output  ADDR_W  POCI mux select, holds frame start address.
REQ-012 frame_err  output  1  sticky: illegal address received in current frame.

Function
REQ-013 Internal frame reset frst_n = rstn AND NOT csn; it SHALL asynchronously clear the bit counter, shift register, state, cur_addr, wr_en and frame_err.
REQ-014 Bit counter SHALL count sclk rising edges 0..DATA_W-1 and wrap to 0; a word completes on the edge where the counter equals DATA_W-1.
REQ-015 Assembled word SHALL be {shift[DATA_W-2:0], serial_in} at the completing edge.
REQ-016 FSM states: ADDR (reset state), DATA, IGNORE.
REQ-017 ADDR, word complete, word < NUM_REGS: rd_addr <= word, cur_addr <= word, go to DATA.
REQ-018 ADDR, word complete, word >= NUM_REGS: frame_err <= 1, rd_addr unchanged, go to IGNORE.
REQ-019 DATA, word complete: wr_data <= word, wr_addr <= cur_addr, wr_en <= 1, cur_addr advances per REQ-027/028.
REQ-020 wr_en SHALL be high from the completing edge until the next sclk rising edge or frame reset, whichever comes first; never two consecutive cycles for one word.
REQ-021 IGNORE: all further words discarded, no wr_en, until frame reset.
REQ-022 Partial word when csn rises: discarded, no write, no error.
REQ-023 wr_addr, wr_data and rd_addr SHALL hold their last values across frame reset; only rstn clears them.
REQ-024 Latency: wr_en asserts on the same sclk edge that samples the last data bit (0 cycles after last bit).

Reset
REQ-025 rstn low: wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, frame_err=0, state=ADDR, bit counter=0, cur_addr=0.
REQ-026 rstn or csn asserted mid-word or mid-frame SHALL take effect immediately without waiting for sclk.

Configuration
REQ-027 Macro PICO_AUTO_INC_EN defined: after each data word, cur_addr <= cur_addr+1, wrapping from NUM_REGS-1 to 0.
REQ-028 Macro PICO_AUTO_INC_EN undefined: cur_addr constant for the frame; every data word writes to the frame start address.

Verification (DATA_W=8, NUM_REGS=16)
REQ-029 Frame 0x03,0xA5,0x5A with AUTO_INC -> wr_en pulses at bit 16 and bit 24; (addr 3,data 0xA5) then (4,0x5A); rd_addr=3; frame_err=0.
REQ-030 Same frame without AUTO_INC -> writes (3,0xA5) then (3,0x5A).
REQ-031 Frame 0x0F,0x11,0x22 with AUTO_INC -> writes (15,0x11) then (0,0x22): wrap-around.
REQ-032 Frame 0x20,0x77 -> frame_err=1 after bit 8, no wr_en, rd_addr keeps previous value; csn high clears frame_err.
REQ-033 Frame 0x02 then 5 bits of data then csn high -> no write; next frame 0x06,0x99 writes (6,0x99) with bit counter restarted.
REQ-034 rstn low during bit 4 of a data word -> all outputs 0 immediately; after release a full frame 0x01,0xC3 writes (1,0xC3).

Source files
------------

// File: rtl/pico_frame_decoder.sv
// -----------------------------------------------------------------------------
// pico_frame_decoder
//
// Decodes SPI-style write frames into register-bank write strobes. A frame
// is the span during which csn is low. The first DATA_W-bit word of a frame
// is a register address; every following word is data written to that
// register. With PICO_AUTO_INC_EN defined, the target address advances by one
// (wrapping at NUM_REGS) after each data word. Without it, every data word
// goes to the frame start address. An out-of-range address flags frame_err
// and discards the rest of the frame.
//
// Configuration macro: PICO_AUTO_INC_EN (undefined = fixed address per frame)
//
// Parameters:
//   DATA_W    serial word width in bits (4..32)
//   NUM_REGS  number of addressable registers (2..256, <= 2**DATA_W)
//
// Ports:
//   sclk       in   SPI clock, all state updates on the rising edge
//   rstn       in   asynchronous active-low reset
//   csn        in   chip select, active-low; high ends/aborts the frame
//   serial_in  in   serial data, MSB first
//   wr_en      out  one-cycle write strobe
//   wr_addr    out  target register of the current write
//   wr_data    out  data of the current write
//   rd_addr    out  read mux select, holds the last valid frame start address
//   frame_err  out  sticky illegal-address flag for the current frame
// -----------------------------------------------------------------------------
module pico_frame_decoder #(
    parameter  int DATA_W   = 8,
    parameter  int NUM_REGS = 16,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              sclk,
    input  logic              rstn,
    input  logic              csn,
    input  logic              serial_in,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W:0]   NUM_REGS_X = (DATA_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] MAX_ADDR   = ADDR_W'(NUM_REGS - 1);

    localparam logic [1:0] ST_ADDR   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_IGNORE = 2'd2;

    // Frame-scoped state is cleared whenever the chip is deselected, without
    // waiting for a clock edge (sclk usually stops while csn is high).
    logic frst_n;
    assign frst_n = rstn & ~csn;

    logic [CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
    logic [DATA_W-2:0] shift_q,     shift_d;
    logic [1:0]        state_q,     state_d;
    logic [ADDR_W-1:0] cur_addr_q,  cur_addr_d;
    logic              wr_en_q,     wr_en_d;
    logic              frame_err_q, frame_err_d;
    logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
    logic [DATA_W-1:0] wr_data_q,   wr_data_d;
    logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;

    logic [DATA_W-1:0] word;
    logic              word_done;
    logic              addr_ok;
    logic [ADDR_W-1:0] next_addr;

    // The completing bit is taken straight from serial_in so the write strobe
    // rises on the same edge that samples the last data bit.
    always_comb begin
        word      = {shift_q, serial_in};
        word_done = (bit_cnt_q == LAST_BIT);
        addr_ok   = ({1'b0, word} < NUM_REGS_X);
    end

`ifdef PICO_AUTO_INC_EN
    always_comb begin
        next_addr = (cur_addr_q == MAX_ADDR) ? '0 : cur_addr_q + 1'b1;
    end
`else
    always_comb begin
        next_addr = cur_addr_q;
    end
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        bit_cnt_d   = word_done ? '0 : bit_cnt_q + 1'b1;
        shift_d     = word[DATA_W-2:0];
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        wr_en_d     = 1'b0;
        frame_err_d = frame_err_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_addr_d   = rd_addr_q;

        if (word_done) begin
            case (state_q)
                ST_ADDR: begin
                    if (addr_ok) begin
                        rd_addr_d  = word[ADDR_W-1:0];
                        cur_addr_d = word[ADDR_W-1:0];
                        state_d    = ST_DATA;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_IGNORE;
                    end
                end
                ST_DATA: begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = cur_addr_q;
                    wr_data_d  = word;
                    cur_addr_d = next_addr;
                end
                default: begin
                    state_d = ST_IGNORE;
                end
            endcase
        end
    end

    // Frame-scoped state: cleared by rstn or by deselect.
    always_ff @(posedge sclk or negedge frst_n) begin
        if (!frst_n) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            state_q     <= ST_ADDR;
            cur_addr_q  <= '0;
            wr_en_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            wr_en_q     <= wr_en_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Write/read address and data survive deselect; only rstn clears them.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
        end else begin
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign rd_addr   = rd_addr_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_pico_frame_decoder.sv
// -----------------------------------------------------------------------------
// tb_pico_frame_decoder
//
// Self-checking bench for pico_frame_decoder (DATA_W=8, NUM_REGS=16).
// Directed frames come from a table of {frame, expected writes} records. The
// multi-cycle cases (reset mid-word) are hand-written. Random frames are
// checked against a frame-level reference model. The bench follows
// PICO_AUTO_INC_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_pico_frame_decoder;

    localparam int DW = 8;
    localparam int NR = 16;
    localparam int AW = $clog2(NR);

`ifdef PICO_AUTO_INC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif

    logic          sclk;
    logic          rstn;
    logic          csn;
    logic          serial_in;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr;
    logic          frame_err;

    pico_frame_decoder #(.DATA_W(DW), .NUM_REGS(NR)) dut (
        .sclk      (sclk),
        .rstn      (rstn),
        .csn       (csn),
        .serial_in (serial_in),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .frame_err (frame_err)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    typedef struct {
        int                nw;       // full words sent (address + data)
        int                partial;  // extra bits of word[nw] before deselect
        logic [3:0][7:0]   w;        // w[0] is the address word
        int                nwr;      // expected number of writes
        logic [2:0][3:0]   wa;       // expected write addresses
        logic [2:0][7:0]   wd;       // expected write data
        int                rd;       // expected rd_addr at end of frame
        bit                err;      // expected frame_err at end of frame
    } vec_t;

    vec_t tbl[7];

    int n_tests = 0;
    int n_fail  = 0;

    int got_a[$], got_d[$], got_b[$];
    int exp_a[$], exp_d[$];
    int bit_no;
    bit prev_wr;
    int last_wa, last_wd, m_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive the top nb bits of w, MSB first; sample outputs 1 time unit after
    // each rising edge and log any write strobe with its bit position.
    task automatic send_bits(input logic [7:0] w, input int nb);
        for (int i = 0; i < nb; i++) begin
            serial_in = w[7-i];
            @(posedge sclk);
            #1;
            bit_no++;
            if (wr_en) begin
                check("wr_en_single_cycle", 32'(prev_wr), 32'd0);
                got_a.push_back(int'(wr_addr));
                got_d.push_back(int'(wr_data));
                got_b.push_back(bit_no);
            end
            prev_wr = wr_en;
        end
    endtask

    task automatic run_frame(input logic [3:0][7:0] w, input int nw, input int partial,
                             input int exp_rd, input bit exp_err, input string tag);
        got_a.delete(); got_d.delete(); got_b.delete();
        bit_no  = 0;
        prev_wr = 1'b0;
        @(negedge sclk);
        csn = 1'b0;
        for (int k = 0; k < nw; k++) send_bits(w[k], 8);
        if (partial > 0) send_bits(w[nw], partial);

        check({tag, "_frame_err"}, 32'(frame_err), 32'(exp_err));
        check({tag, "_rd_addr"}, 32'(rd_addr), 32'(exp_rd));
        check({tag, "_n_writes"}, 32'(got_a.size()), 32'(exp_a.size()));
        for (int k = 0; k < got_a.size() && k < exp_a.size(); k++) begin
            check($sformatf("%s_wr_addr%0d", tag, k), 32'(got_a[k]), 32'(exp_a[k]));
            check($sformatf("%s_wr_data%0d", tag, k), 32'(got_d[k]), 32'(exp_d[k]));
            check($sformatf("%s_wr_bit%0d", tag, k), 32'(got_b[k]), 32'(8 * (k + 2)));
        end
        if (exp_a.size() > 0) begin
            last_wa = exp_a[exp_a.size()-1];
            last_wd = exp_d[exp_d.size()-1];
        end

        // Deselect mid-cycle: error clears at once, write/read outputs hold.
        csn = 1'b1;
        serial_in = 1'b0;
        #1;
        check({tag, "_err_clr"}, 32'(frame_err), 32'd0);
        check({tag, "_wr_addr_hold"}, 32'(wr_addr), 32'(last_wa));
        check({tag, "_wr_data_hold"}, 32'(wr_data), 32'(last_wd));
        check({tag, "_rd_addr_hold"}, 32'(rd_addr), 32'(exp_rd));
    endtask

    // Frame-level reference: first word selects the register, each further
    // full word is one write; a partial trailing word has no effect.
    task automatic model_frame(input logic [3:0][7:0] w, input int nw, output bit err);
        int a;
        exp_a.delete(); exp_d.delete();
        err = 1'b0;
        a = int'(w[0]);
        if (a >= NR) begin
            err = 1'b1;
        end else begin
            m_rd = a;
            for (int k = 1; k < nw; k++) begin
                exp_a.push_back(a);
                exp_d.push_back(int'(w[k]));
                if (AI) a = (a + 1) % NR;
            end
        end
    endtask

    initial begin
        bit err;
        logic [3:0][7:0] rw;
        int nw, partial;

        csn = 1'b1; serial_in = 1'b0; rstn = 1'b0;
        last_wa = 0; last_wd = 0; m_rd = 0;

        tbl[0] = '{nw: 3, partial: 0, w: {8'h00, 8'h5A, 8'hA5, 8'h03}, nwr: 2,
                   wa: {4'd0, (AI ? 4'd4 : 4'd3), 4'd3}, wd: {8'h00, 8'h5A, 8'hA5},
                   rd: 3, err: 1'b0};
        tbl[1] = '{nw: 3, partial: 0, w: {8'h00, 8'h22, 8'h11, 8'h0F}, nwr: 2,
                   wa: {4'd0, (AI ? 4'd0 : 4'd15), 4'd15}, wd: {8'h00, 8'h22, 8'h11},
                   rd: 15, err: 1'b0};
        tbl[2] = '{nw: 2, partial: 0, w: {8'h00, 8'h00, 8'h77, 8'h20}, nwr: 0,
                   wa: '0, wd: '0, rd: 15, err: 1'b1};
        tbl[3] = '{nw: 1, partial: 5, w: {8'h00, 8'h00, 8'hB7, 8'h02}, nwr: 0,
                   wa: '0, wd: '0, rd: 2, err: 1'b0};
        tbl[4] = '{nw: 2, partial: 0, w: {8'h00, 8'h00, 8'h99, 8'h06}, nwr: 1,
                   wa: {4'd0, 4'd0, 4'd6}, wd: {8'h00, 8'h00, 8'h99},
                   rd: 6, err: 1'b0};
        tbl[5] = '{nw: 2, partial: 0, w: {8'h00, 8'h00, 8'hFF, 8'h00}, nwr: 1,
                   wa: {4'd0, 4'd0, 4'd0}, wd: {8'h00, 8'h00, 8'hFF},
                   rd: 0, err: 1'b0};
        tbl[6] = '{nw: 2, partial: 0, w: {8'h00, 8'h00, 8'h44, 8'h10}, nwr: 0,
                   wa: '0, wd: '0, rd: 0, err: 1'b1};

        // Reset state.
        #12;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        @(negedge sclk);
        rstn = 1'b1;
        repeat (2) @(negedge sclk);

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            exp_a.delete(); exp_d.delete();
            for (int k = 0; k < tbl[i].nwr; k++) begin
                exp_a.push_back(int'(tbl[i].wa[k]));
                exp_d.push_back(int'(tbl[i].wd[k]));
            end
            run_frame(tbl[i].w, tbl[i].nw, tbl[i].partial, tbl[i].rd, tbl[i].err,
                      $sformatf("vec%0d", i));
            m_rd = tbl[i].rd;
            repeat (2) @(negedge sclk);
        end

        // rstn asserted during bit 4 of a data word clears everything at once.
        got_a.delete(); got_d.delete(); got_b.delete();
        bit_no = 0; prev_wr = 1'b0;
        @(negedge sclk);
        csn = 1'b0;
        send_bits(8'h01, 8);
        send_bits(8'hC3, 4);
        rstn = 1'b0;
        #1;
        check("midrst_wr_en", 32'(wr_en), 32'd0);
        check("midrst_wr_addr", 32'(wr_addr), 32'd0);
        check("midrst_wr_data", 32'(wr_data), 32'd0);
        check("midrst_rd_addr", 32'(rd_addr), 32'd0);
        check("midrst_frame_err", 32'(frame_err), 32'd0);
        check("midrst_no_write", 32'(got_a.size()), 32'd0);
        csn = 1'b1;
        serial_in = 1'b0;
        @(negedge sclk);
        rstn = 1'b1;
        last_wa = 0; last_wd = 0; m_rd = 0;
        repeat (2) @(negedge sclk);

        exp_a.delete(); exp_d.delete();
        exp_a.push_back(1); exp_d.push_back(8'hC3);
        run_frame({8'h00, 8'h00, 8'hC3, 8'h01}, 2, 0, 1, 1'b0, "post_rst");
        m_rd = 1;
        repeat (2) @(negedge sclk);

        // Random frames against the reference model.
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < 4; k++) rw[k] = 8'($urandom);
            rw[0]   = 8'($urandom_range(0, NR + 3));
            nw      = int'($urandom_range(1, 4));
            partial = (nw < 4) ? int'($urandom_range(0, 7)) : 0;
            model_frame(rw, nw, err);
            run_frame(rw, nw, partial, m_rd, err, $sformatf("rnd%0d", r));
            repeat (int'($urandom_range(1, 3))) @(negedge sclk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
